// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the multi-cycle ALU.
package alu_pkg;

    localparam int ALU_CTRL_W = 6;

    typedef enum logic [ALU_CTRL_W-1:0] {
        OP_AND  = 6'h00,
        OP_OR   = 6'h01,
        OP_ADD  = 6'h02,
        OP_SUB  = 6'h06,
        OP_SLT  = 6'h07,
        OP_SLTU = 6'h08,
        OP_XOR  = 6'h09,
        OP_SLL  = 6'h0A,
        OP_SRL  = 6'h0B,
        OP_SRA  = 6'h0C,
        OP_MUL  = 6'h10,
        OP_DIVU = 6'h11,
        OP_REMU = 6'h12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_state_t;

    function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of every single-cycle opcode; flags undefined opcodes.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    output logic [WIDTH-1:0]      result,
    output logic                  illegal_op
);

    logic [SHW-1:0] shamt;
    assign shamt = operand_b[SHW-1:0];

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result     = '0;
        illegal_op = 1'b0;
        case (alu_control)
            OP_AND:  result = operand_a & operand_b;
            OP_OR:   result = operand_a | operand_b;
            OP_ADD:  result = operand_a + operand_b;
            OP_SUB:  result = operand_a - operand_b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_XOR:  result = operand_a ^ operand_b;
            OP_SLL:  result = operand_a << shamt;
            OP_SRL:  result = operand_a >> shamt;
            OP_SRA:  result = $unsigned($signed(operand_a) >>> shamt);
            // Multi-cycle opcodes are legal but produced by the sequencer in alu_mc.
            OP_MUL, OP_DIVU, OP_REMU: result = '0;
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_core, shift-add MUL and restoring DIVU/REMU,
// with a valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      alu_result,
    output logic                  illegal_op
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    alu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             op_rem;
    logic [WIDTH-1:0] reg_a;   // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] reg_b;   // multiplier, or divisor
    logic [WIDTH-1:0] acc;     // partial product, or partial remainder

    logic             accept, is_mul, is_div, last_iter;
    logic [WIDTH-1:0] core_result;
    logic             core_illegal;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_control == OP_MUL);
    assign is_div    = is_div_op(alu_control);
    assign last_iter = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result      (core_result),
        .illegal_op  (core_illegal)
    );

    // One iteration of each multi-cycle algorithm, evaluated from the current registers.
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, div_rem_next, div_quo_next;

    always_comb begin
        mul_acc_next = reg_b[0] ? (acc + reg_a) : acc;
        rem_shift    = {acc, reg_a[WIDTH-1]};
        div_ge       = (rem_shift >= {1'b0, reg_b});
        // The true difference is below 2^WIDTH whenever it is taken, so modular low bits suffice.
        div_sub      = rem_shift[WIDTH-1:0] - reg_b;
        div_rem_next = div_ge ? div_sub : rem_shift[WIDTH-1:0];
        div_quo_next = {reg_a[WIDTH-2:0], div_ge};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul)      state_next = MUL;
                    else if (is_div) state_next = DIV;
                    else             state_next = DONE;
                end
            end
            MUL:     if (last_iter) state_next = DONE;
            DIV:     if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            op_rem     <= 1'b0;
            reg_a      <= '0;
            reg_b      <= '0;
            acc        <= '0;
            alu_result <= '0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        op_rem <= (alu_control == OP_REMU);
                        reg_a  <= operand_a;
                        reg_b  <= operand_b;
                        acc    <= '0;
                        if (is_mul || is_div) begin
                            illegal_op <= 1'b0;
                        end else begin
                            alu_result <= core_result;
                            illegal_op <= core_illegal;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_acc_next;
                    reg_a <= reg_a << 1;
                    reg_b <= reg_b >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) alu_result <= mul_acc_next;
                end
                DIV: begin
                    acc   <= div_rem_next;
                    reg_a <= div_quo_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) alu_result <= op_rem ? div_rem_next : div_quo_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver queues expected results from a reference model,
// a monitor pops and compares them whenever a result is presented.
module tb_alu_mc;

    localparam int WIDTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [5:0]        alu_control = '0;
    logic [WIDTH-1:0]  operand_a = '0;
    logic [WIDTH-1:0]  operand_b = '0;
    logic              in_ready, out_valid, illegal_op;
    logic [WIDTH-1:0]  alu_result;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc_cyc;
        int          stall;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model written from the opcode definitions with plain arithmetic.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
        logic [63:0] p;
        logic [4:0]  s;
        s   = b[4:0];
        r   = '0;
        ill = 1'b0;
        case (op)
            6'h00: r = a & b;
            6'h01: r = a | b;
            6'h02: r = a + b;
            6'h06: r = a - b;
            6'h07: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            6'h08: r = {31'b0, (a < b)};
            6'h09: r = a ^ b;
            6'h0A: r = a << s;
            6'h0B: r = a >> s;
            6'h0C: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            6'h10: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
            end
            6'h11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            6'h12: r = (b == 0) ? a : a % b;
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic bit is_long(input logic [5:0] op);
        return (op == 6'h10) || (op == 6'h11) || (op == 6'h12);
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        txn_t t;
        int   waited = 0;
        @(negedge clock);
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        while (in_ready !== 1'b1) begin
            @(negedge clock);
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
        end
        t.op = op;
        model(op, a, b, t.res, t.ill);
        t.lat     = is_long(op) ? WIDTH + 1 : 1;
        t.acc_cyc = cyc;
        t.stall   = stall;
        exp_q.push_back(t);
        @(posedge clock);
        #1;
        // Scramble inputs so results depend only on what was captured at acceptance.
        in_valid    = 1'b0;
        alu_control = 6'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !mon_busy) return;
            @(negedge clock);
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares each presented result, applies the requested backpressure, then releases it.
    initial begin
        txn_t        t;
        logic [31:0] held;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && out_valid === 1'b1) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(alu_result), 64'(0));
                    out_ready = 1'b1;
                    @(negedge clock);
                    out_ready = 1'b0;
                end else begin
                    t = exp_q.pop_front();
                    check($sformatf("result_op%02h", t.op), 64'(alu_result), 64'(t.res));
                    check($sformatf("illegal_op%02h", t.op), 64'(illegal_op), 64'(t.ill));
                    check($sformatf("latency_op%02h", t.op), 64'(cyc - t.acc_cyc), 64'(t.lat));
                    held = alu_result;
                    for (int i = 0; i < t.stall; i++) begin
                        @(negedge clock);
                        check("hold_out_valid", 64'(out_valid), 64'(1));
                        check("hold_result", 64'(alu_result), 64'(held));
                        check("hold_in_ready", 64'(in_ready), 64'(0));
                    end
                    out_ready = 1'b1;
                    @(negedge clock);
                    out_ready = 1'b0;
                    check("post_out_valid", 64'(out_valid), 64'(0));
                    check("post_in_ready", 64'(in_ready), 64'(1));
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] legal [13];
        logic [5:0] op;
        legal = '{6'h00, 6'h01, 6'h02, 6'h06, 6'h07, 6'h08, 6'h09,
                  6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11, 6'h12};

        #1 reset = 1'b1;
        #11;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(alu_result), 64'(0));
        check("reset_illegal", 64'(illegal_op), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 check("in_ready_after_reset", 64'(in_ready), 64'(1));

        issue(6'h0C, 32'hFFFF_FFFF, 32'h3, 0);
        issue(6'h0B, 32'hFFFF_FFFF, 32'h3, 0);
        issue(6'h02, 32'hFFFF_FFFF, 32'h1, 0);
        issue(6'h10, 32'h0000_1234, 32'h10, 0);
        issue(6'h10, 32'h0001_0000, 32'h0001_0000, 1);
        issue(6'h11, 32'd100, 32'd7, 0);
        issue(6'h12, 32'd100, 32'd7, 0);
        issue(6'h11, 32'd7, 32'd0, 0);
        issue(6'h12, 32'd7, 32'd0, 0);
        issue(6'h02, 32'h1111_2222, 32'h3333_4444, 5);
        issue(6'h3F, 32'h5, 32'h6, 0);
        issue(6'h01, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        issue(6'h07, 32'hFFFF_FFFE, 32'h1, 0);
        issue(6'h08, 32'hFFFF_FFFE, 32'h1, 0);
        issue(6'h0A, 32'h1, 32'hFFFF_FFE5, 0);
        drain();

        // Abandon a multiply mid-flight with an asynchronous reset.
        issue(6'h10, $urandom, $urandom, 0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midop_reset_out_valid", 64'(out_valid), 64'(0));
        check("midop_reset_result", 64'(alu_result), 64'(0));
        check("midop_reset_illegal", 64'(illegal_op), 64'(0));
        exp_q.delete(exp_q.size() - 1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 check("in_ready_after_midop_reset", 64'(in_ready), 64'(1));
        issue(6'h02, 32'd2, 32'd3, 0);
        drain();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) < 13) op = legal[$urandom_range(0, 12)];
            else                            op = 6'($urandom);
            issue(op, rnd_operand(), rnd_operand(), $urandom_range(0, 3));
        end
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
